// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO slave port among NUM_REQ requesters.
// Latency: grant and slave access on the first edge, ack one edge after s_done. Backpressure: s_done=0 holds ISSUE.
// Requests are level signals; losers keep waiting, so no request is lost.
module gpio_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ-1:0]      req_re,
  input  logic [3*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    s_en,
  output logic [2:0]              s_addr,
  output logic [1:0]              s_size,
  output logic                    s_we,
  output logic                    s_re,
  output logic [31:0]             s_wd_data,
  input  logic [31:0]             s_rd_data,
  input  logic                    s_done,
  input  logic                    s_check
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] WMASK = (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF
                                  : 32'((64'd1 << GPIO_WIDTH) - 64'd1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 s_en_q, s_en_d, s_we_q, s_we_d, s_re_q, s_re_d;
  logic [2:0]           s_addr_q, s_addr_d;
  logic [31:0]          s_wd_data_q, s_wd_data_d;
  logic [IW-1:0]        ptr_q, ptr_d, win_q, win_d;
  logic                 illegal_q, illegal_d, chk0_q, chk0_d;

  logic                 found;
  logic [IW-1:0]        pick, cand;
  logic [IW:0]          sum;
  logic                 op_we, op_re, op_ill;

  // Scan from the rotating pointer, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    s_en_d      = s_en_q;
    s_we_d      = s_we_q;
    s_re_d      = s_re_q;
    s_addr_d    = s_addr_q;
    s_wd_data_d = s_wd_data_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    illegal_d   = illegal_q;
    chk0_d      = chk0_q;
    op_we       = req_we[pick];
    op_re       = req_re[pick];
    op_ill      = (op_we == op_re);

    case (state_q)
      IDLE: begin
        if (found) begin
          win_d       = pick;
          s_addr_d    = req_addr[3*int'(pick) +: 3];
          s_wd_data_d = req_wdata[32*int'(pick) +: 32] & WMASK;
          illegal_d   = op_ill;
          s_en_d      = ~op_ill;
          s_we_d      = op_we & ~op_ill;
          s_re_d      = op_re & ~op_ill;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          chk0_d      = s_check;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // An illegal op never reaches the slave, so it must not wait on s_done.
        if (illegal_q || s_done) begin
          rsp_rdata_d  = s_re_q ? s_rd_data : 32'd0;
          rsp_err_d    = illegal_q | (s_check & ~chk0_q);
          ack_d[win_q] = 1'b1;
          s_en_d       = 1'b0;
          s_we_d       = 1'b0;
          s_re_d       = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IW'(NUM_REQ-1)) ? '0 : win_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      s_en_q      <= 1'b0;
      s_we_q      <= 1'b0;
      s_re_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wd_data_q <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      illegal_q   <= 1'b0;
      chk0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      s_en_q      <= s_en_d;
      s_we_q      <= s_we_d;
      s_re_q      <= s_re_d;
      s_addr_q    <= s_addr_d;
      s_wd_data_q <= s_wd_data_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      illegal_q   <= illegal_d;
      chk0_q      <= chk0_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign s_en      = s_en_q;
  assign s_we      = s_we_q;
  assign s_re      = s_re_q;
  assign s_addr    = s_addr_q;
  assign s_wd_data = s_wd_data_q;
  assign s_size    = 2'b00;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with an expected-response queue popped on each ack.
module tb_gpio_bus_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0, req_we = '0, req_re = '0;
  logic [3*N-1:0]  req_addr = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, ack;
  logic [31:0]     rsp_rdata, s_wd_data, s_rd_data;
  logic            rsp_err, s_en, s_we, s_re;
  logic [2:0]      s_addr;
  logic [1:0]      s_size;
  logic            s_done = 1'b1, s_check = 1'b0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, t0 = 0, last_ack = 0;

  gpio_bus_arbiter #(.NUM_REQ(N), .GPIO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_re(req_re),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .s_en(s_en), .s_addr(s_addr),
    .s_size(s_size), .s_we(s_we), .s_re(s_re), .s_wd_data(s_wd_data),
    .s_rd_data(s_rd_data), .s_done(s_done), .s_check(s_check)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave read data depends on the address so a wrong address shows up.
  assign s_rd_data = (s_addr == 3'b001) ? 32'h0000_003C : (32'hDEAD_0000 | 32'(s_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic post(input int idx, input logic we, input logic re,
                      input logic [2:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    req_we[idx]            = we;
    req_re[idx]            = re;
    req_addr[3*idx +: 3]   = addr;
    req_wdata[32*idx +: 32] = wd;
    req[idx]               = 1'b1;
    e.idx = idx; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    t0 = cyc;
  endtask

  // Advances at least one cycle, then waits (bounded) for ack and scores it.
  task automatic wait_ack(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ack == '0) begin
      chk({tag, "_timeout"}, 32'(ack), 32'hFFFF_FFFF);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_ack"}, 32'(ack), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ack"}, 32'(ack), 32'(1 << e.idx));
      chk({tag, "_gnt"}, 32'(gnt), 32'(1 << e.idx));
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      last_ack = cyc;
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_s_en", 32'(s_en), 0);
    chk("rst_s_we_re", 32'({s_we, s_re}), 0);
    chk("rst_s_addr", 32'(s_addr), 0);
    chk("rst_s_wd", s_wd_data, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("s_size", 32'(s_size), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write with wide data masked to GPIO width.
    post(1, 1'b1, 1'b0, 3'b100, 32'h1A5, 32'h0, 1'b0);
    @(negedge clk);
    chk("wr_s_en", 32'(s_en), 1);
    chk("wr_s_we_re", 32'({s_we, s_re}), 32'b10);
    chk("wr_s_addr", 32'(s_addr), 32'h4);
    chk("wr_s_wd", s_wd_data, 32'h0A5);
    chk("wr_gnt", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    wait_ack("wr");
    chk("wr_latency", 32'(last_ack - t0), 2);

    // Read from requester 0 while requester 2 also asks: pointer at 2 picks 2 first.
    post(2, 1'b1, 1'b0, 3'b011, 32'h55, 32'h0, 1'b0);
    post(0, 1'b0, 1'b1, 3'b001, 32'h0, 32'h3C, 1'b0);
    wait_ack("ptr2");
    req[2] = 1'b0;
    wait_ack("rd");
    req[0] = 1'b0;

    // Illegal op from requester 2 (ptr now 1): slave never selected.
    @(negedge clk);
    post(2, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("ill_s_en", 32'(s_en), 0);
    chk("ill_gnt", 32'(gnt), 32'b0100);
    wait_ack("ill");
    req[2] = 1'b0;

    // Write from 3 whose access raises the sticky slave error.
    @(negedge clk);
    post(3, 1'b1, 1'b0, 3'b010, 32'h7, 32'h0, 1'b1);
    @(negedge clk);
    s_check = 1'b1;
    wait_ack("err");
    req[3] = 1'b0;
    @(negedge clk);
    s_check = 1'b0;

    // Fairness: all held, pointer back at 0 -> 0,1,2,3,0 every 3 cycles.
    @(negedge clk);
    for (int i = 0; i < N; i++) post(i, 1'b1, 1'b0, 3'(i), 32'(i), 32'h0, 1'b0);
    post(0, 1'b1, 1'b0, 3'd0, 32'd0, 32'h0, 1'b0);
    exp_q.delete(exp_q.size() - 1);
    begin
      exp_t e;
      e.idx = 0; e.rdata = 32'h0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    wait_ack("fair0");
    chk("fair_first_lat", 32'(last_ack - t0), 2);
    for (int k = 1; k < 5; k++) begin
      int prev;
      prev = last_ack;
      wait_ack($sformatf("fair%0d", k));
      chk($sformatf("fair%0d_interval", k), 32'(last_ack - prev), 3);
    end
    req = '0;

    // Wait states: s_done low for three ISSUE cycles (ptr now 1).
    @(negedge clk);
    @(negedge clk);
    s_done = 1'b0;
    post(1, 1'b1, 1'b0, 3'b110, 32'hFF33, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ws_hold%0d", k), {s_en, s_we, s_addr, s_wd_data[26:0]},
          {1'b1, 1'b1, 3'b110, 27'h33});
    end
    s_done = 1'b1;
    wait_ack("ws");
    chk("ws_latency", 32'(last_ack - t0), 5);
    req[1] = 1'b0;

    // Reset in ISSUE abandons the access; afterwards requester 3 wins alone.
    @(negedge clk);
    s_done = 1'b0;
    req[2]    = 1'b1;
    req_we[2] = 1'b1;
    req_re[2] = 1'b0;
    @(negedge clk);
    chk("mid_s_en_pre", 32'(s_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_gnt", 32'(gnt), 0);
    chk("mid_ack", 32'(ack), 0);
    chk("mid_s_en", 32'(s_en), 0);
    req    = '0;
    s_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    post(3, 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
    wait_ack("post_rst");
    chk("post_rst_latency", 32'(last_ack - t0), 2);
    req[3] = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ack", 32'(ack), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
